br_commit_unit: RTL

BR_COMMIT_UNIT -- requirements
Module: br_commit_unit

---
 rtl/br_commit_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/br_commit_unit.sv
// In-order commit queue for control-flow instructions: tracks predictions, retires resolved
// branches, drives predictor updates and misprediction flushes. Optional: BR_COMMIT_STATS_EN.
module br_commit_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        alloc_valid,
  input  logic [31:0] alloc_pc,
  input  logic        alloc_is_br,
  input  logic [31:0] alloc_pred_pc,
  output logic        alloc_ready,
  output logic [3:0]  alloc_tag,
  input  logic        res_valid,
  input  logic [3:0]  res_tag,
  input  logic        res_jump,
  input  logic [31:0] res_target,
  output logic        rob_br,
  output logic        rob_br_jump,
  output logic [31:0] rob_br_pc,
  output logic        flush,
  output logic [31:0] flush_pc
`ifdef BR_COMMIT_STATS_EN
  ,
  output logic [31:0] stat_commits,
  output logic [31:0] stat_mispred
`endif
);

  logic [31:0] ent_pc      [16];
  logic [31:0] ent_pred_pc [16];
  logic [31:0] ent_target  [16];
  logic [15:0] ent_is_br;
  logic [15:0] ent_jump;
  logic [15:0] ent_resolved;

  logic [3:0]  head;
  logic [3:0]  tail;
  logic [4:0]  count;

  logic        full;
  logic        alloc_fire;
  logic [3:0]  res_offset;
  logic        res_hit;
  logic        res_fire;
  logic        commit;
  logic [31:0] head_actual;
  logic        mispred;
  logic        do_flush;

  assign full        = (count == 5'd16);
  assign alloc_ready = !full && !flush;
  assign alloc_tag   = tail;
  assign alloc_fire  = rdy && alloc_valid && alloc_ready;

  // A tag is occupied when its distance from head lies inside the live window.
  assign res_offset  = res_tag - head;
  assign res_hit     = ({1'b0, res_offset} < count);
  assign res_fire    = rdy && !flush && res_valid && res_hit;

  assign commit      = rdy && !flush && (count != 5'd0) && ent_resolved[head];
  assign head_actual = ent_jump[head] ? ent_target[head] : ent_pc[head] + 32'd4;
  assign mispred     = (head_actual != ent_pred_pc[head]);
  assign do_flush    = commit && mispred;

  // Payload storage needs no reset: an entry is only read after it has been allocated.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent_pc[tail]      <= alloc_pc;
      ent_pred_pc[tail] <= alloc_pred_pc;
      ent_is_br[tail]   <= alloc_is_br;
    end
    if (res_fire) begin
      ent_jump[res_tag]   <= res_jump;
      ent_target[res_tag] <= res_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_resolved <= '0;
    end else begin
      if (alloc_fire) ent_resolved[tail] <= 1'b0;
      if (res_fire)   ent_resolved[res_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (do_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc_fire) tail <= tail + 4'd1;
        if (commit)     head <= head + 4'd1;
        case ({alloc_fire, commit})
          2'b10:   count <= count + 5'd1;
          2'b01:   count <= count - 5'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Commit-side outputs are one-cycle pulses; they hold while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rob_br      <= 1'b0;
      rob_br_jump <= 1'b0;
      rob_br_pc   <= '0;
      flush       <= 1'b0;
      flush_pc    <= '0;
    end else if (rdy) begin
      rob_br      <= commit && ent_is_br[head];
      rob_br_jump <= commit && ent_is_br[head] && ent_jump[head];
      rob_br_pc   <= (commit && ent_is_br[head]) ? ent_pc[head] : '0;
      flush       <= do_flush;
      flush_pc    <= do_flush ? head_actual : '0;
    end
  end

`ifdef BR_COMMIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits <= '0;
      stat_mispred <= '0;
    end else begin
      if (commit)   stat_commits <= stat_commits + 32'd1;
      if (do_flush) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule
